// File: rtl/fifo_rd_packer_if.sv
// Bundle of signals between the async FIFO read port, the packer and the
// downstream word stream. The packer takes the master modport; the
// environment (FIFO read side plus downstream consumer) takes the slave one.
interface fifo_rd_packer_if #(
  parameter int DSIZE = 8,
  parameter int RATIO = 4
);
  localparam int CW = $clog2(RATIO + 1);

  // FIFO read port (first-word-fall-through)
  logic                   rempty;
  logic [DSIZE-1:0]       rdata;
  logic                   rinc;

  // Partial-word flush request
  logic                   flush;

  // Packed output stream
  logic [RATIO*DSIZE-1:0] out_data;
  logic [CW-1:0]          out_cnt;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    input  rempty, rdata, flush, out_ready,
    output rinc, out_data, out_cnt, out_valid
  );

  modport slave (
    output rempty, rdata, flush, out_ready,
    input  rinc, out_data, out_cnt, out_valid
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO packer: pops DSIZE-bit entries and packs RATIO of them into
// one wide word (lane 0 = oldest), presented on a valid/ready stream. Partial
// words are pushed out on an explicit flush or after TIMEOUT idle cycles.
module fifo_rd_packer #(
  parameter int DSIZE   = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  fifo_rd_packer_if.master bus
);

  localparam int CW = $clog2(RATIO + 1);
  localparam int LW = $clog2(RATIO);
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] FULL = CW'(RATIO);
  localparam logic [IW-1:0] TMAX = IW'(TIMEOUT);

  logic [RATIO-1:0][DSIZE-1:0] acc;
  logic [CW-1:0]               cnt;
  logic [IW-1:0]               idle_cnt;
  logic                        flush_pend;

  logic [RATIO*DSIZE-1:0]      out_data_r;
  logic [CW-1:0]               out_cnt_r;
  logic                        out_valid_r;

  logic                        oslot;
  logic                        timeout_hit;
  logic                        emit;
  logic                        pop;
  logic [LW-1:0]               wr_lane;
  logic [RATIO-1:0][DSIZE-1:0] packed_word;

  assign bus.out_data  = out_data_r;
  assign bus.out_cnt   = out_cnt_r;
  assign bus.out_valid = out_valid_r;
  assign bus.rinc      = pop;

  // Emit/pop decisions; a pop on the emit edge refills lane 0 so full-rate
  // input produces back-to-back words without a bubble.
  always_comb begin
    oslot       = !out_valid_r || bus.out_ready;
    timeout_hit = (TIMEOUT > 0) && (idle_cnt == TMAX);
    emit        = oslot && ((cnt == FULL) ||
                            ((cnt != '0) && (flush_pend || bus.flush || timeout_hit)));
    pop         = !rrst && !bus.rempty && ((cnt != FULL) || emit);
    wr_lane     = emit ? '0 : cnt[LW-1:0];
  end

  // Outgoing word: lanes at or above the fill count are zeroed
  always_comb begin
    packed_word = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (CW'(i) < cnt) packed_word[i] = acc[i];
    end
  end

  // Accumulator, lane count, idle timer, pending flush and output register
  always_ff @(posedge rclk) begin
    if (rrst) begin
      acc         <= '0;
      cnt         <= '0;
      idle_cnt    <= '0;
      flush_pend  <= 1'b0;
      out_data_r  <= '0;
      out_cnt_r   <= '0;
      out_valid_r <= 1'b0;
    end else begin
      if (emit) begin
        out_data_r  <= packed_word;
        out_cnt_r   <= cnt;
        out_valid_r <= 1'b1;
      end else if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end

      if (pop) acc[wr_lane] <= bus.rdata;

      if (pop)       cnt <= emit ? CW'(1) : cnt + CW'(1);
      else if (emit) cnt <= '0;

      if (emit)                          flush_pend <= 1'b0;
      else if (bus.flush && cnt != '0)   flush_pend <= 1'b1;

      if (TIMEOUT == 0 || emit || pop || cnt == '0) begin
        idle_cnt <= '0;
      end else if (cnt != FULL && idle_cnt != TMAX) begin
        idle_cnt <= idle_cnt + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer (DSIZE=8, RATIO=4, TIMEOUT=16) with a
// simple FWFT FIFO model on the read side and a word monitor on the output.
module tb_fifo_rd_packer;
  localparam int DSIZE   = 8;
  localparam int RATIO   = 4;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  cnt;
    int          cyc;
  } word_t;

  logic       rclk = 1'b0;
  logic       rrst;

  logic [7:0] mem [256];
  logic [7:0] wr_ptr;
  logic [7:0] rd_ptr = '0;

  word_t      words[$];
  int         cyc  = 0;
  int         vcyc = 0;
  int         gaps = 0;
  bit         stream_on;

  int         n_assert;
  int         n_fail;
  int         wb;
  int         vb;

  fifo_rd_packer_if #(.DSIZE(DSIZE), .RATIO(RATIO)) bus ();

  fifo_rd_packer #(.DSIZE(DSIZE), .RATIO(RATIO), .TIMEOUT(TIMEOUT)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus)
  );

  always #5 rclk = ~rclk;

  assign bus.rempty = (rd_ptr == wr_ptr);
  assign bus.rdata  = mem[rd_ptr];

  // FIFO pop side and output monitor, sampled on the active edge
  always @(posedge rclk) begin
    cyc <= cyc + 1;
    if (!rrst) begin
      if (bus.out_valid) vcyc <= vcyc + 1;
      if (bus.out_valid && bus.out_ready)
        words.push_back('{bus.out_data, bus.out_cnt, cyc});
      if (stream_on && !bus.rempty && !bus.rinc) gaps <= gaps + 1;
    end
    if (bus.rinc) rd_ptr <= rd_ptr + 8'd1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge rclk);
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  function automatic word_t wd(input int i);
    word_t w;
    w.data = '0;
    w.cnt  = '0;
    w.cyc  = 0;
    if (i >= 0 && i < words.size()) w = words[i];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    wr_ptr        = '0;
    stream_on     = 1'b0;
    rrst          = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    tick(2);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data",  64'(bus.out_data),  64'd0);
    chk("rst_cnt",   64'(bus.out_cnt),   64'd0);
    chk("rst_rinc",  64'(bus.rinc),      64'd0);
    rrst = 1'b0;
    tick(1);

    // 1: one full word
    wb = words.size();
    vb = vcyc;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    tick(10);
    chk("t1_nwords", 64'(words.size() - wb), 64'd1);
    chk("t1_data",   64'(wd(wb).data),       64'h44332211);
    chk("t1_cnt",    64'(wd(wb).cnt),        64'd4);
    chk("t1_vcyc",   64'(vcyc - vb),         64'd1);

    // 2: backpressure, then drain in order
    wb = words.size();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) push(8'(i));
    tick(12);
    chk("t2_valid",  64'(bus.out_valid),     64'd1);
    chk("t2_data",   64'(bus.out_data),      64'h04030201);
    chk("t2_cnt",    64'(bus.out_cnt),       64'd4);
    chk("t2_rinc",   64'(bus.rinc),          64'd0);
    chk("t2_level",  64'(8'(wr_ptr - rd_ptr)), 64'd2);
    chk("t2_nwords", 64'(words.size() - wb), 64'd0);
    tick(5);
    chk("t2_stable", 64'(bus.out_data),      64'h04030201);
    bus.out_ready = 1'b1;
    tick(25);
    chk("t2_nwords_end", 64'(words.size() - wb), 64'd3);
    chk("t2_w0",     64'(wd(wb).data),       64'h04030201);
    chk("t2_w1",     64'(wd(wb + 1).data),   64'h08070605);
    chk("t2_w2",     64'(wd(wb + 2).data),   64'h00000A09);
    chk("t2_w2_cnt", 64'(wd(wb + 2).cnt),    64'd2);
    chk("t2_empty",  64'(8'(wr_ptr - rd_ptr)), 64'd0);

    // 3: idle timeout, exact edge
    push(8'hA1); push(8'hB2);
    tick(18);
    chk("t3_early",  64'(bus.out_valid),     64'd0);
    tick(1);
    chk("t3_valid",  64'(bus.out_valid),     64'd1);
    chk("t3_data",   64'(bus.out_data),      64'h0000B2A1);
    chk("t3_cnt",    64'(bus.out_cnt),       64'd2);
    tick(2);

    // 4: flush with nothing buffered, flush of a partial word, pending flush
    wb = words.size();
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    tick(3);
    chk("t4_idle_valid", 64'(bus.out_valid), 64'd0);
    chk("t4_idle_words", 64'(words.size() - wb), 64'd0);
    push(8'hC1); push(8'hC2); push(8'hC3);
    tick(3);
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    chk("t4_valid",  64'(bus.out_valid),     64'd1);
    chk("t4_data",   64'(bus.out_data),      64'h00C3C2C1);
    chk("t4_cnt",    64'(bus.out_cnt),       64'd3);
    bus.out_ready = 1'b0;
    push(8'hD1);
    tick(1);
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    tick(3);
    chk("t4_hold",   64'(bus.out_data),      64'h00C3C2C1);
    bus.out_ready = 1'b1;
    tick(1);
    chk("t4_pend_valid", 64'(bus.out_valid), 64'd1);
    chk("t4_pend_data",  64'(bus.out_data),  64'h000000D1);
    chk("t4_pend_cnt",   64'(bus.out_cnt),   64'd1);
    tick(2);

    // 5: reset mid-word
    push(8'h5A); push(8'h5B);
    tick(3);
    rrst = 1'b1;
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    #1;
    chk("t5_rinc_rst", 64'(bus.rinc),        64'd0);
    tick(1);
    chk("t5_valid",  64'(bus.out_valid),     64'd0);
    chk("t5_data",   64'(bus.out_data),      64'd0);
    chk("t5_cnt",    64'(bus.out_cnt),       64'd0);
    chk("t5_level",  64'(8'(wr_ptr - rd_ptr)), 64'd4);
    rrst = 1'b0;
    wb = words.size();
    tick(10);
    chk("t5_nwords", 64'(words.size() - wb), 64'd1);
    chk("t5_word",   64'(wd(wb).data),       64'h88776655);
    chk("t5_wcnt",   64'(wd(wb).cnt),        64'd4);

    // 6: streaming 64 entries
    wb = words.size();
    stream_on = 1'b1;
    for (int i = 0; i < 64; i++) push(8'(i));
    tick(70);
    stream_on = 1'b0;
    chk("t6_nwords", 64'(words.size() - wb), 64'd16);
    for (int k = 0; k < 16; k++) begin
      chk("t6_word", 64'(wd(wb + k).data),
          64'({8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1), 8'(4*k)}));
      chk("t6_cnt",  64'(wd(wb + k).cnt), 64'd4);
    end
    chk("t6_first",  64'(wd(wb).data),       64'h03020100);
    chk("t6_last",   64'(wd(wb + 15).data),  64'h3F3E3D3C);
    chk("t6_span",   64'(wd(wb + 15).cyc - wd(wb).cyc), 64'd60);
    chk("t6_gaps",   64'(gaps),              64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
